// File: rtl/sim_run_ctrl_if.sv
// Core-side bus of the simulation run controller.
// Carries the core's fetch/retire view (pc, instruction, instr_valid)
// into the controller. It carries the controller's status and counters
// (core_rst, running, done, halted, timeout, cycle_count, instret) back out.
// master: the core / harness side. slave: the controller.
interface sim_run_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic            instr_valid;
    logic            core_rst;
    logic            running;
    logic            done;
    logic            halted;
    logic            timeout;
    logic [31:0]     cycle_count;
    logic [31:0]     instret;

    modport master (
        output pc,
        output instruction,
        output instr_valid,
        input  core_rst,
        input  running,
        input  done,
        input  halted,
        input  timeout,
        input  cycle_count,
        input  instret
    );

    modport slave (
        input  pc,
        input  instruction,
        input  instr_valid,
        output core_rst,
        output running,
        output done,
        output halted,
        output timeout,
        output cycle_count,
        output instret
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the core in reset, lets it run, and ends
// the run on an ecall, a stalled pc, or an exhausted cycle budget.
// Ports: clk, rst (sync, active-high), bus (slave side of sim_run_ctrl_if).
// All status outputs are registered.
module sim_run_ctrl #(
    parameter int          XLEN        = 32,
    parameter int unsigned RST_CYCLES  = 1,
    parameter int unsigned MAX_CYCLES  = 23,
    parameter int unsigned STALL_LIMIT = 4,
    parameter logic [31:0] HALT_INSTR  = 32'h00000073
) (
    input logic         clk,
    input logic         rst,
    sim_run_ctrl_if.slave bus
);
    localparam logic [31:0] HOLD_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] CYC_LAST   = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] STALL_LAST = 32'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [31:0]     hold_cnt;
    logic [31:0]     stall_cnt;
    logic [XLEN-1:0] prev_pc;
    logic            prev_ok;

    logic            core_rst_q;
    logic            running_q;
    logic            done_q;
    logic            halted_q;
    logic            timeout_q;
    logic [31:0]     cyc_q;
    logic [31:0]     ir_q;

    logic            is_ecall;
    logic            pc_same;
    logic            stall_hit;
    logic            budget_hit;

    // prev_ok masks the compare on the first RUN cycle, when prev_pc
    // still holds nothing meaningful.
    always_comb begin
        is_ecall   = bus.instr_valid && (bus.instruction == HALT_INSTR);
        pc_same    = prev_ok && (bus.pc == prev_pc);
        stall_hit  = pc_same && (stall_cnt == STALL_LAST);
        budget_hit = (cyc_q == CYC_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            stall_cnt  <= '0;
            prev_pc    <= '0;
            prev_ok    <= 1'b0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            cyc_q      <= '0;
            ir_q       <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        hold_cnt   <= '0;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end
                end
                RUN: begin
                    cyc_q   <= cyc_q + 32'd1;
                    prev_pc <= bus.pc;
                    prev_ok <= 1'b1;
                    if (bus.instr_valid) begin
                        ir_q <= ir_q + 32'd1;
                    end
                    if (pc_same) begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end else begin
                        stall_cnt <= '0;
                    end
                    // A halt in the budget's last cycle still counts as halt.
                    if (is_ecall || stall_hit) begin
                        state      <= DONE;
                        halted_q   <= 1'b1;
                        done_q     <= 1'b1;
                        running_q  <= 1'b0;
                        core_rst_q <= 1'b1;
                    end else if (budget_hit) begin
                        state      <= DONE;
                        timeout_q  <= 1'b1;
                        done_q     <= 1'b1;
                        running_q  <= 1'b0;
                        core_rst_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    assign bus.core_rst    = core_rst_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.halted      = halted_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cyc_q;
    assign bus.instret     = ir_q;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl.
// Three instances: defaults, RST_CYCLES=3, MAX_CYCLES=8.
module tb_sim_run_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;

    always #5 clk = ~clk;

    logic        o_crst [3];
    logic        o_run  [3];
    logic        o_done [3];
    logic        o_halt [3];
    logic        o_to   [3];
    logic [31:0] o_cc   [3];
    logic [31:0] o_ir   [3];

    sim_run_ctrl_if #(.XLEN(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].pc          = pc;
        assign bus[g].instruction = instr;
        assign bus[g].instr_valid = valid;
        assign o_crst[g] = bus[g].core_rst;
        assign o_run[g]  = bus[g].running;
        assign o_done[g] = bus[g].done;
        assign o_halt[g] = bus[g].halted;
        assign o_to[g]   = bus[g].timeout;
        assign o_cc[g]   = bus[g].cycle_count;
        assign o_ir[g]   = bus[g].instret;

        sim_run_ctrl #(
            .XLEN        (32),
            .RST_CYCLES  ((g == 1) ? 3 : 1),
            .MAX_CYCLES  ((g == 2) ? 8 : 23),
            .STALL_LIMIT (4),
            .HALT_INSTR  (32'h00000073)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    typedef struct {
        string name;
        int    sel;
        int    ecall_at;
        int    stall_from;
        int    vmode;
        int    exp_hold;
        logic  exp_halt;
        logic  exp_to;
        int    exp_cc;
        int    exp_ir;
    } vec_t;

    typedef struct {
        logic        halt;
        logic        to;
        logic [31:0] cc;
        logic [31:0] ir;
    } res_t;

    vec_t vecs [8];
    res_t sbq [$];
    int   total = 0;
    int   bad   = 0;
    int   sel   = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int k);
        valid = (v.vmode == 0) || (k % 2 == 0);
        if (v.stall_from >= 0 && k >= v.stall_from) pc = 32'h10;
        else pc = 32'h1000 + 32'(4 * k);
        instr = (k == v.ecall_at) ? 32'h73 : 32'h13;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_crst"}, 32'(o_crst[sel]), 32'd1);
        chk({tag, "_run"},  32'(o_run[sel]),  32'd0);
        chk({tag, "_done"}, 32'(o_done[sel]), 32'd0);
        chk({tag, "_flags"}, 32'({o_halt[sel], o_to[sel]}), 32'd0);
        chk({tag, "_cc"},   o_cc[sel], 32'd0);
        chk({tag, "_ir"},   o_ir[sel], 32'd0);
    endtask

    // Count negedge samples with core_rst high until running appears.
    task automatic wait_run(output int hold_n);
        bit seen = 0;
        hold_n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (o_run[sel]) seen = 1;
            else begin
                if (o_crst[sel]) hold_n++;
                @(negedge clk);
            end
        end
        chk("run_start", 32'(o_run[sel]), 32'd1);
        chk("run_cc0", o_cc[sel], 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int   hold_n;
        int   k;
        bit   fin;
        res_t e;
        sel = v.sel;
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; pc = '0; instr = '0;
        @(negedge clk);
        chk_reset({v.name, "_rst"});
        rst = 1'b0;
        wait_run(hold_n);
        chk({v.name, "_hold"}, 32'(hold_n), 32'(v.exp_hold));
        sbq.push_back('{v.exp_halt, v.exp_to, 32'(v.exp_cc), 32'(v.exp_ir)});
        k = 0;
        fin = 0;
        while (!fin && k < 40) begin
            drive(v, k);
            @(negedge clk);
            k++;
            if (o_done[sel]) fin = 1;
        end
        chk({v.name, "_done"}, 32'(o_done[sel]), 32'd1);
        e = sbq.pop_front();
        chk({v.name, "_halt"}, 32'(o_halt[sel]), 32'(e.halt));
        chk({v.name, "_to"},   32'(o_to[sel]),   32'(e.to));
        chk({v.name, "_cc"},   o_cc[sel], e.cc);
        chk({v.name, "_ir"},   o_ir[sel], e.ir);
        chk({v.name, "_crst"}, 32'(o_crst[sel]), 32'd1);
        chk({v.name, "_run"},  32'(o_run[sel]),  32'd0);
        for (int j = 0; j < 3; j++) begin
            drive(v, k + j);
            @(negedge clk);
        end
        chk({v.name, "_frz_cc"}, o_cc[sel], e.cc);
        chk({v.name, "_frz_ir"}, o_ir[sel], e.ir);
        chk({v.name, "_frz_flags"}, 32'({o_done[sel], o_halt[sel], o_to[sel]}),
            32'({1'b1, e.halt, e.to}));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   hold_n;
        vec_t m;
        rst = 1'b1; valid = 1'b0; pc = '0; instr = '0;

        vecs[0] = '{"timeout_dflt",    0, -1, -1, 0, 1, 1'b0, 1'b1, 23, 23};
        vecs[1] = '{"rst3_ecall0",     1,  0, -1, 0, 3, 1'b1, 1'b0,  1,  1};
        vecs[2] = '{"ecall_at5",       0,  5, -1, 0, 1, 1'b1, 1'b0,  6,  6};
        vecs[3] = '{"stall_pc10",      0, -1,  2, 0, 1, 1'b1, 1'b0,  7,  7};
        vecs[4] = '{"mc8_ecall_last",  2,  7, -1, 0, 1, 1'b1, 1'b0,  8,  8};
        vecs[5] = '{"mc8_timeout",     2, -1, -1, 0, 1, 1'b0, 1'b1,  8,  8};
        vecs[6] = '{"ecall_at_budget", 0, 22, -1, 0, 1, 1'b1, 1'b0, 23, 23};
        vecs[7] = '{"gap_valid",       0,  3, -1, 1, 1, 1'b0, 1'b1, 23, 12};

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset mid-RUN, then a fresh run, then reset from DONE.
        m = '{"midrun", 0, -1, -1, 0, 1, 1'b0, 1'b0, 0, 0};
        sel = 0;
        @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_run(hold_n);
        for (int k = 0; k < 10; k++) begin
            drive(m, k);
            @(negedge clk);
        end
        chk("mid_cc10", o_cc[0], 32'd10);
        drive(m, 10);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("mid_rst");
        rst = 1'b0;
        valid = 1'b0;
        wait_run(hold_n);
        m.ecall_at = 1;
        for (int k = 0; k < 2; k++) begin
            drive(m, k);
            @(negedge clk);
        end
        chk("rerun_done", 32'(o_done[0]), 32'd1);
        chk("rerun_halt", 32'(o_halt[0]), 32'd1);
        chk("rerun_cc", o_cc[0], 32'd2);
        chk("rerun_ir", o_ir[0], 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("done_rst");
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
